// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, word type, S-box and rcon.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [31:0] word_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, so 0 maps to 0) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constants for rounds 1..10
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit combinational AES S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Pure lookup; no state
    always_comb begin
        o_byte = sbox(i_byte);
    end

endmodule

// File: rtl/single_key_expansion.sv
// Iterative AES-128 key schedule: captures a cipher key, then emits round keys 1..10
// on ten consecutive cycles. Optional round_idx output enabled by KEYEXP_ROUND_IDX_EN.
module single_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,     // active-high asynchronous reset despite the name
    input  logic         IN_valid,
    input  logic [127:0] key,
    output logic         OUT_valid,
    output logic [127:0] RoundKey
`ifdef KEYEXP_ROUND_IDX_EN
    ,
    output logic [3:0]   round_idx
`endif
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    logic         r_state;
    logic [3:0]   r_round;
    logic [127:0] r_key;
    logic [127:0] r_round_key;
    logic         r_out_valid;

    word_t        w_w0, w_w1, w_w2, w_w3;
    word_t        w_rot;
    word_t        w_sub;
    word_t        w_t;
    word_t        w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;
    logic         w_last;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // RotWord: one-byte left rotate
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    // Next-key datapath shared by all rounds
    always_comb begin
        w_t        = w_sub ^ {rcon(r_round), 24'h000000};
        w_n0       = w_w0 ^ w_t;
        w_n1       = w_w1 ^ w_n0;
        w_n2       = w_w2 ^ w_n1;
        w_n3       = w_w3 ^ w_n2;
        w_next_key = {w_n0, w_n1, w_n2, w_n3};
        w_last     = (r_round == 4'(NR));
    end

    // FSM, round counter, key register and registered outputs
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state     <= STATE_IDLE;
            r_round     <= 4'd0;
            r_key       <= 128'h0;
            r_round_key <= 128'h0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (IN_valid) begin
                        r_key   <= key;
                        r_round <= 4'd1;
                        r_state <= STATE_RUN;
                    end
                end
                default: begin
                    r_key       <= w_next_key;
                    r_round_key <= w_next_key;
                    r_out_valid <= 1'b1;
                    r_round     <= r_round + 4'd1;
                    if (w_last) r_state <= STATE_IDLE;
                end
            endcase
        end
    end

`ifdef KEYEXP_ROUND_IDX_EN
    logic [3:0] r_round_idx;

    // Index of the key currently on RoundKey, updated with it
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_round_idx <= 4'd0;
        end else if (r_state == STATE_RUN) begin
            r_round_idx <= r_round;
        end
    end

    assign round_idx = r_round_idx;
`endif

    assign OUT_valid = r_out_valid;
    assign RoundKey  = r_round_key;

endmodule

// File: tb/tb_single_key_expansion.sv
// Self-checking bench for single_key_expansion against a word-array key-schedule model.
module tb_single_key_expansion;

    logic         clk;
    logic         reset_n;
    logic         IN_valid;
    logic [127:0] key;
    logic         OUT_valid;
    logic [127:0] RoundKey;
`ifdef KEYEXP_ROUND_IDX_EN
    logic [3:0]   round_idx;
`endif

    int n_pass;
    int n_total;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];

    single_key_expansion dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .IN_valid  (IN_valid),
        .key       (key),
        .OUT_valid (OUT_valid),
        .RoundKey  (RoundKey)
`ifdef KEYEXP_ROUND_IDX_EN
        ,
        .round_idx (round_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return r;
    endfunction

    // S-box by brute-force inverse search plus the affine transform
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // Classic 44-word expansion; rcon generated by repeated doubling
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        exp_rk[0] = k;
        for (int r = 1; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        IN_valid = 1'b1;
        key      = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (OUT_valid !== 1'b0 || RoundKey !== 128'h0)
                $display("FAIL reset_hold: OUT_valid=%b RoundKey=%h required 0/0", OUT_valid, RoundKey);
            else n_pass++;
        end
`ifdef KEYEXP_ROUND_IDX_EN
        n_total++;
        if (round_idx !== 4'd0) $display("FAIL reset_idx: got %0d required 0", round_idx);
        else n_pass++;
`endif
        IN_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        n_total++;
        if (OUT_valid !== 1'b0) $display("FAIL post_reset_idle: OUT_valid=%b required 0", OUT_valid);
        else n_pass++;
    endtask

    // Pulse a key, optionally scramble key/IN_valid during RUN, check all 10 keys
    task automatic test_sequence(input logic [127:0] k, input bit disturb);
        model_expand(k);
        @(posedge clk); #1;
        key = k; IN_valid = 1'b1;
        @(posedge clk); #1;
        IN_valid = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            @(posedge clk); #1;
            if (disturb) begin
                key      = {$urandom, $urandom, $urandom, $urandom};
                IN_valid = (r < 10);
            end
            @(negedge clk);
            n_total++;
            if (OUT_valid !== 1'b1 || RoundKey !== exp_rk[r])
                $display("FAIL rk%0d: OUT_valid=%b RoundKey=%h required 1/%h",
                         r, OUT_valid, RoundKey, exp_rk[r]);
            else n_pass++;
`ifdef KEYEXP_ROUND_IDX_EN
            n_total++;
            if (round_idx !== 4'(r)) $display("FAIL round_idx: got %0d required %0d", round_idx, r);
            else n_pass++;
`endif
        end
        IN_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (OUT_valid !== 1'b0 || RoundKey !== exp_rk[10])
            $display("FAIL done: OUT_valid=%b RoundKey=%h required 0/%h",
                     OUT_valid, RoundKey, exp_rk[10]);
        else n_pass++;
    endtask

    task automatic test_known_vectors();
        test_sequence(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        n_total++;
        if (exp_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
            exp_rk[2] !== 128'hf2c295f27a96b9435935807a7359f67f ||
            exp_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("FAIL fips_model: rk1=%h rk10=%h", exp_rk[1], exp_rk[10]);
        else n_pass++;
        test_sequence(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        n_total++;
        if (exp_rk[1] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe ||
            exp_rk[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
            $display("FAIL seq_model: rk1=%h rk10=%h", exp_rk[1], exp_rk[10]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        @(posedge clk); #1;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c; IN_valid = 1'b1;
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int r = 1; r <= 10; r++) begin
                @(posedge clk);
                @(negedge clk);
                n_total++;
                if (OUT_valid !== 1'b1 || RoundKey !== exp_rk[r])
                    $display("FAIL held s%0d rk%0d: OUT_valid=%b RoundKey=%h required 1/%h",
                             s, r, OUT_valid, RoundKey, exp_rk[r]);
                else n_pass++;
            end
            if (s == 1) IN_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n_total++;
            if (OUT_valid !== 1'b0) $display("FAIL held_gap s%0d: OUT_valid=%b required 0", s, OUT_valid);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++)
            test_sequence({$urandom, $urandom, $urandom, $urandom}, i[0]);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        key = {$urandom, $urandom, $urandom, $urandom}; IN_valid = 1'b1;
        @(posedge clk); #1;
        IN_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_total++;
        if (OUT_valid !== 1'b0 || RoundKey !== 128'h0)
            $display("FAIL async_reset: OUT_valid=%b RoundKey=%h required 0/0", OUT_valid, RoundKey);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (OUT_valid !== 1'b0) $display("FAIL after_abort: OUT_valid=%b required 0", OUT_valid);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset_n  = 1'b1;
        IN_valid = 1'b0;
        key      = '0;
        build_sbox();
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
